// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: walks an 8-bit register list from R0 upward for LM/SM.
// Each selected register gets one SCAN cycle and then an ACCESS phase that
// lasts until mem_ready. The SCAN cycle selects the register and loads the
// memory address. The ACCESS phase drives one memory access and, for LM only,
// the register-file write strobe.
module lm_sm_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned NREG   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode,
    input  logic [NREG-1:0]           reg_list,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      mem_ready,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREG)-1:0]   rf_addr,
    output logic                      rf_write_n,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         next_addr
);

    localparam int unsigned RA_W = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NREG-1:0]     list_q, list_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NREG-1:0]     list_rest;

    logic                busy_d, done_d, mem_read_d, mem_write_d;
    logic [RA_W-1:0]     rf_addr_d;
    logic [ADDR_W-1:0]   mem_addr_d, next_addr_d;

    // Index of the lowest set bit; R0 has the highest priority
    function automatic logic [RA_W-1:0] lowest_set(input logic [NREG-1:0] v);
        lowest_set = '0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = RA_W'(i);
        end
    endfunction

    // Remaining list once the lowest set bit (the register being serviced) is cleared
    assign list_rest = list_q & (list_q - NREG'(1));

    // State, latched transfer context and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            list_q    <= '0;
            mode_q    <= 1'b0;
            addr_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_addr   <= '0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            next_addr <= '0;
        end else begin
            state_q   <= state_d;
            list_q    <= list_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            busy      <= busy_d;
            done      <= done_d;
            rf_addr   <= rf_addr_d;
            mem_addr  <= mem_addr_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            next_addr <= next_addr_d;
        end
    end

    // Next-state and transfer-context update
    always_comb begin
        state_d = state_q;
        list_d  = list_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    list_d  = reg_list;
                    mode_d  = mode;
                    addr_d  = base_addr;
                    state_d = (reg_list == '0) ? DONE : SCAN;
                end
            end
            SCAN: state_d = ACCESS;
            ACCESS: begin
                if (mem_ready) begin
                    list_d  = list_rest;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = (list_rest == '0) ? DONE : SCAN;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: registered outputs follow the next state; write strobe is combinational
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        mem_read_d  = (state_d == ACCESS) && !mode_d;
        mem_write_d = (state_d == ACCESS) && mode_d;
        rf_addr_d   = rf_addr;
        mem_addr_d  = mem_addr;
        next_addr_d = next_addr;
        if (state_q == SCAN) rf_addr_d = lowest_set(list_q);
        if (state_d == SCAN) mem_addr_d = addr_d;
        if (state_d == DONE) next_addr_d = addr_d;
        rf_write_n = !((state_q == ACCESS) && !mode_q && mem_ready);
    end

endmodule
